// File: rtl/memdata_ctrl16.sv
// ---------------------------------------------------------------------------
// memdata_ctrl16
//
// Purpose:
//   Sits between the CPU load/store path and an external byte-wide data
//   memory. The memory writes synchronously and reads combinationally. Each
//   CPU request is a byte or a 16-bit little-endian halfword. A halfword is
//   split into two sequential byte accesses: the low byte at addr and the
//   high byte at addr+1 (modulo 2^AW). Completion is a one-cycle ack pulse.
//
// Ports:
//   clk          system clock, all state changes on posedge
//   reset        synchronous active-high reset
//   req          CPU request strobe, only looked at while idle
//   rw           1 = store, 0 = load (captured with req)
//   half         1 = halfword, 0 = byte (captured with req)
//   addr         CPU byte address (captured with req)
//   wdata        store data; a byte store uses wdata[7:0] (captured with req)
//   rdata        load result; a byte load is zero-extended; held until the
//                next load completes
//   busy         high in every state except idle
//   ack          one-cycle completion pulse
//   mem_cs       memory chip select
//   mem_we       memory write enable
//   mem_oe       memory output enable
//   mem_dir      memory byte address
//   mem_indata   memory write data
//   mem_outdata  memory read data (may float when cs/oe are low)
// ---------------------------------------------------------------------------
module memdata_ctrl16 #(
    parameter int AW   = 12,
    parameter int MEMW = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req,
    input  logic                rw,
    input  logic                half,
    input  logic [AW-1:0]       addr,
    input  logic [2*MEMW-1:0]   wdata,
    output logic [2*MEMW-1:0]   rdata,
    output logic                busy,
    output logic                ack,
    output logic                mem_cs,
    output logic                mem_we,
    output logic                mem_oe,
    output logic [AW-1:0]       mem_dir,
    output logic [MEMW-1:0]     mem_indata,
    input  logic [MEMW-1:0]     mem_outdata
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LO   = 2'd1,
        S_HI   = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic                rw_q, rw_d;
    logic                half_q, half_d;
    logic [AW-1:0]       addr_q, addr_d;
    logic [2*MEMW-1:0]   wdata_q, wdata_d;
    logic [2*MEMW-1:0]   rdata_q, rdata_d;
    // Last driven memory address/data, so the bus stays quiet between accesses.
    logic [AW-1:0]       dir_q;
    logic [MEMW-1:0]     indata_q;
    logic                access;

    // Address of the high byte; wraps naturally at 2^AW.
    function automatic logic [AW-1:0] hi_addr(input logic [AW-1:0] a);
        return a + AW'(1);
    endfunction

    // Next-state and CPU-side register updates.
    always_comb begin
        state_d = state_q;
        rw_d    = rw_q;
        half_d  = half_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;

        unique case (state_q)
            S_IDLE: begin
                if (req) begin
                    rw_d    = rw;
                    half_d  = half;
                    addr_d  = addr;
                    wdata_d = wdata;
                    state_d = S_LO;
                end
            end
            S_LO: begin
                if (!rw_q) begin
                    rdata_d[MEMW-1:0] = mem_outdata;
                    // A byte load is zero-extended.
                    if (!half_q) begin
                        rdata_d[2*MEMW-1:MEMW] = '0;
                    end
                end
                state_d = half_q ? S_HI : S_DONE;
            end
            S_HI: begin
                if (!rw_q) begin
                    rdata_d[2*MEMW-1:MEMW] = mem_outdata;
                end
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Memory-side decode: depends only on the state and captured fields.
    // Strobes are forced low while reset is asserted so that an access in
    // flight is not completed on the reset edge.
    always_comb begin
        access     = (state_q == S_LO) || (state_q == S_HI);
        mem_cs     = access && !reset;
        mem_we     = mem_cs && rw_q;
        mem_oe     = mem_cs && !rw_q;
        mem_dir    = dir_q;
        mem_indata = indata_q;
        if (state_q == S_LO) begin
            mem_dir    = addr_q;
            mem_indata = wdata_q[MEMW-1:0];
        end else if (state_q == S_HI) begin
            mem_dir    = hi_addr(addr_q);
            mem_indata = wdata_q[2*MEMW-1:MEMW];
        end
    end

    always_comb begin
        busy  = (state_q != S_IDLE);
        ack   = (state_q == S_DONE);
        rdata = rdata_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            rw_q     <= 1'b0;
            half_q   <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            dir_q    <= '0;
            indata_q <= '0;
        end else begin
            state_q  <= state_d;
            rw_q     <= rw_d;
            half_q   <= half_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            dir_q    <= mem_dir;
            indata_q <= mem_indata;
        end
    end

endmodule

// File: tb/tb_memdata_ctrl16.sv
module tb_memdata_ctrl16;

    logic        clk = 1'b0;
    logic        reset;
    logic        req;
    logic        rw;
    logic        half;
    logic [11:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    logic        busy, ack, mem_cs, mem_we, mem_oe;
    logic [11:0] mem_dir;
    logic [7:0]  mem_indata;
    wire  [7:0]  mem_outdata;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    memdata_ctrl16 #(.AW(12), .MEMW(8)) dut (
        .clk(clk), .reset(reset), .req(req), .rw(rw), .half(half),
        .addr(addr), .wdata(wdata), .rdata(rdata), .busy(busy), .ack(ack),
        .mem_cs(mem_cs), .mem_we(mem_we), .mem_oe(mem_oe), .mem_dir(mem_dir),
        .mem_indata(mem_indata), .mem_outdata(mem_outdata)
    );

    // External memory model: synchronous write, combinational read.
    logic [7:0] mem [0:4095];
    logic       mem_init;

    function automatic logic [7:0] pat(input int i);
        return 8'((i * 7 + 3) ^ (i >> 4));
    endfunction

    assign mem_outdata = (mem_cs && mem_oe) ? mem[mem_dir] : 8'hzz;

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 4096; i++) mem[i] <= pat(i);
        end else if (mem_cs && mem_we) begin
            mem[mem_dir] <= mem_indata;
        end
    end

    // Reference model: flat byte array plus last load result.
    logic [7:0]  ref_mem [0:4095];
    logic [15:0] rd_model;

    typedef struct {
        int          exp_cyc;
        logic [15:0] exp_rdata;
    } exp_t;
    exp_t sb[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: protocol invariants every cycle, scoreboard pop on ack.
    always @(negedge clk) begin
        if (!reset) begin
            checks++;
            if (mem_we && mem_oe) begin
                errors++;
                $display("FAIL we_oe_exclusive actual=11 required=not both (cycle %0d)", cyc);
            end
            checks++;
            if (mem_cs && (!busy || ack)) begin
                errors++;
                $display("FAIL cs_idle_done actual=1 required=0 (cycle %0d)", cyc);
            end
            if (sb.size() > 0 && cyc > sb[0].exp_cyc) begin
                checks++;
                errors++;
                $display("FAIL ack_timeout actual=none required=cycle %0d", sb[0].exp_cyc);
                void'(sb.pop_front());
            end
            if (ack) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_ack actual=1 required=0 (cycle %0d)", cyc);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("ack_latency", 32'(cyc), 32'(e.exp_cyc));
                    chk("rdata", 32'(rdata), 32'(e.exp_rdata));
                end
            end
        end
    end

    // Apply the reference semantics of one request.
    task automatic model_op(input bit w, input bit h, input logic [11:0] a, input logic [15:0] d);
        logic [11:0] a1;
        a1 = a + 12'd1;
        if (w) begin
            ref_mem[a] = d[7:0];
            if (h) ref_mem[a1] = d[15:8];
        end else begin
            rd_model = h ? {ref_mem[a1], ref_mem[a]} : {8'h00, ref_mem[a]};
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (busy && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (busy) chk("idle_timeout", 32'(busy), 32'd0);
    endtask

    task automatic issue(input bit w, input bit h, input logic [11:0] a, input logic [15:0] d);
        exp_t e;
        wait_idle();
        rw = w; half = h; addr = a; wdata = d; req = 1'b1;
        @(posedge clk);
        #1;
        model_op(w, h, a, d);
        e.exp_cyc   = cyc + (h ? 2 : 1);
        e.exp_rdata = rd_model;
        sb.push_back(e);
        @(negedge clk);
        req = 1'b0;
    endtask

    initial begin
        int e0;
        int diffs;
        exp_t e;
        reset = 1'b1; mem_init = 1'b1;
        req = 1'b0; rw = 1'b0; half = 1'b0; addr = '0; wdata = '0;
        for (int i = 0; i < 4096; i++) ref_mem[i] = pat(i);
        rd_model = 16'h0000;
        repeat (3) @(posedge clk);
        @(negedge clk);
        mem_init = 1'b0;
        chk("rst_rdata", 32'(rdata), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_ack", 32'(ack), 0);
        chk("rst_ctrl", 32'({mem_cs, mem_we, mem_oe}), 0);
        chk("rst_dir", 32'(mem_dir), 0);
        chk("rst_indata", 32'(mem_indata), 0);
        reset = 1'b0;

        // Halfword store/load.
        issue(1, 1, 12'h010, 16'hBEEF);
        issue(0, 1, 12'h010, 16'h0000);
        // Byte store/load, neighbour untouched.
        issue(1, 0, 12'h020, 16'h1234);
        issue(0, 0, 12'h020, 16'h0000);
        wait_idle();
        chk("byte_st_neighbour", 32'(mem[12'h021]), 32'(pat(12'h021)));
        // Halfword wrap at top of address space.
        issue(1, 1, 12'hFFF, 16'hA55A);
        issue(0, 1, 12'hFFF, 16'h0000);
        wait_idle();
        chk("wrap_lo", 32'(mem[12'hFFF]), 32'h5A);
        chk("wrap_hi", 32'(mem[12'h000]), 32'hA5);

        // Request held during a busy halfword op.
        wait_idle();
        rw = 1'b1; half = 1'b1; addr = 12'h040; wdata = 16'hC3D2; req = 1'b1;
        @(posedge clk);
        #1;
        e0 = cyc;
        model_op(1, 1, 12'h040, 16'hC3D2);
        e.exp_cyc = e0 + 2; e.exp_rdata = rd_model; sb.push_back(e);
        @(negedge clk);
        addr = 12'h030; half = 1'b0; wdata = 16'h0099;
        for (int i = 0; i < 3; i++) begin
            chk("no_early_we_030", 32'(mem_we && mem_dir == 12'h030), 0);
            @(negedge clk);
        end
        chk("held_req_busy_gap", 32'(busy), 0);
        @(posedge clk);
        #1;
        model_op(1, 0, 12'h030, 16'h0099);
        e.exp_cyc = e0 + 5; e.exp_rdata = rd_model; sb.push_back(e);
        @(negedge clk);
        req = 1'b0;
        wait_idle();
        chk("held_req_030", 32'(mem[12'h030]), 32'h99);

        // Reset during the high byte of a halfword store.
        wait_idle();
        rw = 1'b1; half = 1'b1; addr = 12'h050; wdata = 16'h7788; req = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_ack", 32'(ack), 0);
        chk("abort_ctrl", 32'({mem_cs, mem_we, mem_oe}), 0);
        chk("abort_dir", 32'(mem_dir), 0);
        chk("abort_indata", 32'(mem_indata), 0);
        chk("abort_rdata", 32'(rdata), 0);
        reset = 1'b0;
        ref_mem[12'h050] = 8'h88;
        rd_model = 16'h0000;
        chk("abort_lo_written", 32'(mem[12'h050]), 32'h88);
        chk("abort_hi_kept", 32'(mem[12'h051]), 32'(pat(12'h051)));
        repeat (3) @(negedge clk);

        // Randomized traffic.
        for (int i = 0; i < 60; i++) begin
            logic [11:0] a;
            if ($urandom_range(0, 3) == 0) a = 12'hFFF - 12'($urandom_range(0, 1));
            else a = 12'h100 + 12'($urandom_range(0, 31));
            issue(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, 16'($urandom));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        for (int n = 0; n < 20 && sb.size() > 0; n++) @(negedge clk);
        chk("scoreboard_drained", 32'(sb.size()), 0);
        diffs = 0;
        for (int i = 0; i < 4096; i++) if (mem[i] !== ref_mem[i]) diffs++;
        chk("mem_image", 32'(diffs), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/memdata_ctrl16.md
Name: memdata_ctrl16

Overview:
- Bus controller sitting directly upstream of the external data memory (12-bit address, 8-bit data, cs/we/oe control, synchronous write, combinational read).
- Turns single CPU load/store requests of byte or 16-bit halfword size into one or two sequential byte accesses on the memory port.
- Returns read data and a one-cycle completion strobe to the CPU side.
- Halfwords are little-endian: low byte at addr, high byte at addr+1.

Parameters:
- AW, 12, memory address width (dir width).
- MEMW, 8, memory data width; the halfword is 2*MEMW.

Ports:
- clk  in  1  system clock; all state changes on posedge.
- reset  in  1  synchronous, active-high reset; sampled on posedge clk.
- req  in  1  CPU request strobe; sampled only in IDLE.
- rw  in  1  1 = write (store), 0 = read (load); latched with req.
- half  in  1  1 = 16-bit halfword, 0 = byte; latched with req.
- addr  in  AW  CPU byte address; latched with req.
- wdata  in  2*MEMW  store data; byte store uses wdata[7:0]; latched with req.
- rdata  out  2*MEMW  load result; byte load is zero-extended; holds until the next load completes.
- busy  out  1  high in every state except IDLE.
- ack  out  1  one-cycle completion strobe, high in DONE.
- mem_cs  out  1  to memory cs.
- mem_we  out  1  to memory we.
- mem_oe  out  1  to memory oe.
- mem_dir  out  AW  to memory dir.
- mem_indata  out  MEMW  to memory indata.
- mem_outdata  in  MEMW  from memory outdata; combinational read, may be Z when cs or oe is low.

Behaviour:
- Reset values:
  - state = IDLE; rdata = 0; busy = ack = 0.
  - mem_cs = mem_we = mem_oe = 0; mem_dir = 0; mem_indata = 0.
  - All latched request fields = 0.
- FSM states:
  - IDLE: req=1 at posedge latches rw, half, addr, wdata and moves to LO. req=0 stays in IDLE.
  - LO: access at a_lat.
    - Read: mem_cs=1, mem_oe=1; rdata[7:0] <= mem_outdata at posedge.
    - Write: mem_cs=1, mem_we=1, mem_indata=w_lat[7:0]; the memory captures the byte at the same posedge.
    - Next state: half ? HI : DONE. On a byte read, rdata[15:8] <= 0 at this posedge.
  - HI: same as LO at a_lat+1, using rdata[15:8] / w_lat[15:8]. Next state: DONE.
  - DONE: ack=1, busy=1, all memory controls 0. Next state: IDLE.
- Memory-side outputs:
  - Combinational decode of state and latched fields only; no path from the CPU-side inputs.
  - mem_we and mem_oe are never both 1.
  - Outside LO/HI: mem_cs=0 and mem_dir/mem_indata hold their last driven values.
- Latency, counting from the req posedge k:
  - byte: LO in cycle k+1, ack in cycle k+2.
  - half: LO in k+1, HI in k+2, ack in k+3.
  - Next request accepted at the earliest on the posedge that ends DONE+1, i.e. IDLE.
- req asserted while busy is ignored and not queued; the CPU must hold req or reissue it.
- Address arithmetic is modulo 2^AW: a halfword at addr=4095 accesses 4095 then 0. No misalignment fault.
- rdata updates only on reads; writes leave rdata unchanged.
- Reset mid-operation:
  - Next state is IDLE and all outputs take reset values.
  - A byte whose write cycle was already clocked stays in memory; no further byte is written.
  - No ack is issued for the aborted request.
- reset has priority over req on the same edge.

Test Plan:
- Halfword store addr=0x010, wdata=0xBEEF, then halfword load addr=0x010 -> mem[0x010]=0xEF, mem[0x011]=0xBE; load rdata=0xBEEF; ack exactly at k+3 for each.
- Byte store addr=0x020, wdata=0x1234, then byte load 0x020 -> mem[0x020]=0x34, mem[0x021] unchanged; rdata=0x0034; ack at k+2.
- Halfword store addr=0xFFF, wdata=0xA55A -> mem[0xFFF]=0x5A, mem[0x000]=0xA5; load from 0xFFF returns 0xA55A.
- Request with addr=0x030 while busy (req held high during the whole halfword op to 0x040) -> the 0x030 request is not taken until IDLE; a single ack per op; mem_we never asserted at 0x030 before the first ack.
- Reset asserted in HI of a halfword store to 0x050 (wdata=0x7788) -> mem[0x050]=0x88, mem[0x051] unchanged; next cycle all outputs at reset values; no ack.
- Every cycle of all tests -> !(mem_we && mem_oe); mem_cs=0 in IDLE and DONE.
